// File: rtl/sal_bk_req_queue.sv
// Per-bank request queue between address decoder and bank controller; one-cycle push-to-head latency.
// Backpressure: in_ready = !full from registered state only. Optional zero-latency bypass: SAL_BK_REQ_QUEUE_BYPASS_EN.
module sal_bk_req_queue #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4,
  parameter int LEN_W = 4,
  parameter int SEQ_W = 8,
  parameter int RA_W  = 16,
  parameter int CA_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_wr,
  input  logic [ID_W-1:0]          in_id,
  input  logic [LEN_W-1:0]         in_len,
  input  logic [SEQ_W-1:0]         in_seq_num,
  input  logic [RA_W-1:0]          in_ra,
  input  logic [CA_W-1:0]          in_ca,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_wr,
  output logic [ID_W-1:0]          out_id,
  output logic [LEN_W-1:0]         out_len,
  output logic [SEQ_W-1:0]         out_seq_num,
  output logic [RA_W-1:0]          out_ra,
  output logic [CA_W-1:0]          out_ca,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic             wr;
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
    logic [SEQ_W-1:0] seq_num;
    logic [RA_W-1:0]  ra;
    logic [CA_W-1:0]  ca;
  } req_t;

  req_t             mem [DEPTH];
  req_t             in_req;
  req_t             head;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;
  logic             pass;

  assign in_req = '{wr: in_wr, id: in_id, len: in_len, seq_num: in_seq_num, ra: in_ra, ca: in_ca};

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign in_ready = !full;

`ifdef SAL_BK_REQ_QUEUE_BYPASS_EN
  // An empty queue forwards the decoder request straight to the bank controller.
  assign pass      = empty & in_valid & out_ready;
  assign out_valid = !empty | in_valid;
  assign head      = empty ? in_req : mem[rptr];
`else
  assign pass      = 1'b0;
  assign out_valid = !empty;
  assign head      = mem[rptr];
`endif

  assign push = in_valid & in_ready & !pass;
  assign pop  = out_valid & out_ready & !empty;

  assign out_wr      = head.wr;
  assign out_id      = head.id;
  assign out_len     = head.len;
  assign out_seq_num = head.seq_num;
  assign out_ra      = head.ra;
  assign out_ca      = head.ca;

  // Storage carries no reset; out_* are don't-care while out_valid is low.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= in_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(head)));

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= CNT_W'(DEPTH));

  a_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> !full);

  a_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    pop |-> !empty);

endmodule

// File: tb/tb_sal_bk_req_queue.sv
// Scoreboard bench for sal_bk_req_queue; expected entries queue on acceptance and retire on handshake.
module tb_sal_bk_req_queue;

  localparam int DEPTH = 4;
  localparam int ID_W  = 4;
  localparam int LEN_W = 4;
  localparam int SEQ_W = 8;
  localparam int RA_W  = 16;
  localparam int CA_W  = 10;
  localparam int E_W   = 1 + ID_W + LEN_W + SEQ_W + RA_W + CA_W;
`ifdef SAL_BK_REQ_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_wr;
  logic [ID_W-1:0]  in_id;
  logic [LEN_W-1:0] in_len;
  logic [SEQ_W-1:0] in_seq_num;
  logic [RA_W-1:0]  in_ra;
  logic [CA_W-1:0]  in_ca;
  logic             out_valid;
  logic             out_ready;
  logic             out_wr;
  logic [ID_W-1:0]  out_id;
  logic [LEN_W-1:0] out_len;
  logic [SEQ_W-1:0] out_seq_num;
  logic [RA_W-1:0]  out_ra;
  logic [CA_W-1:0]  out_ca;
  logic [2:0]       count;
  logic             full;
  logic             empty;

  int total = 0;
  int bad   = 0;
  logic [E_W-1:0] sb[$];

  sal_bk_req_queue #(
    .DEPTH(DEPTH), .ID_W(ID_W), .LEN_W(LEN_W), .SEQ_W(SEQ_W), .RA_W(RA_W), .CA_W(CA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wr(in_wr), .in_id(in_id), .in_len(in_len), .in_seq_num(in_seq_num),
    .in_ra(in_ra), .in_ca(in_ca),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wr(out_wr), .out_id(out_id), .out_len(out_len), .out_seq_num(out_seq_num),
    .out_ra(out_ra), .out_ca(out_ca),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [E_W-1:0] pack_in();
    return {in_wr, in_id, in_len, in_seq_num, in_ra, in_ca};
  endfunction

  function automatic logic [E_W-1:0] pack_out();
    return {out_wr, out_id, out_len, out_seq_num, out_ra, out_ca};
  endfunction

  task automatic drive_req(input logic [SEQ_W-1:0] seq);
    in_valid   = 1'b1;
    in_wr      = 1'($urandom_range(0, 1));
    in_id      = ID_W'($urandom);
    in_len     = LEN_W'($urandom);
    in_seq_num = seq;
    in_ra      = RA_W'($urandom);
    in_ca      = CA_W'($urandom);
  endtask

  // One clock cycle: entered just after a falling edge, returns just after the next one.
  task automatic tick();
    logic [E_W-1:0] exp_e;
    logic           exp_v;
    #1;
    exp_v = (sb.size() != 0) || (BYP && in_valid);
    total++;
    if (out_valid !== exp_v) begin
      bad++;
      $display("FAIL out_valid: got %b want %b (t=%0t)", out_valid, exp_v, $time);
    end
    total++;
    if (in_ready !== (sb.size() < DEPTH)) begin
      bad++;
      $display("FAIL in_ready: got %b want %b (t=%0t)", in_ready, sb.size() < DEPTH, $time);
    end
    if (in_valid && in_ready) sb.push_back(pack_in());
    if (out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL pop_empty: handshake with nothing expected (t=%0t)", $time);
      end else begin
        exp_e = sb.pop_front();
        if (pack_out() !== exp_e) begin
          bad++;
          $display("FAIL head: got %h want %h (t=%0t)", pack_out(), exp_e, $time);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (count !== 3'(sb.size())) begin
      bad++;
      $display("FAIL count: got %0d want %0d (t=%0t)", count, sb.size(), $time);
    end
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic drain();
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) if (sb.size() != 0) tick();
    out_ready = 1'b0;
    total++;
    if (empty !== 1'b1 || sb.size() != 0) begin
      bad++;
      $display("FAIL drain: empty=%b left=%0d want empty=1 left=0", empty, sb.size());
    end
  endtask

  task automatic test_reset();
    idle();
    in_wr = 0; in_id = 0; in_len = 0; in_seq_num = 0; in_ra = 0; in_ca = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({empty, full, out_valid, in_ready, count} !== {4'b1001, 3'd0}) begin
      bad++;
      $display("FAIL reset: e/f/v/r/cnt=%b%b%b%b/%0d want 1001/0", empty, full, out_valid, in_ready, count);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [E_W-1:0] exp_e;
    idle();
    in_valid = 1'b1; in_wr = 1'b1; in_id = 4'd3; in_len = 4'd7;
    in_seq_num = 8'h10; in_ra = 16'h1234; in_ca = 10'h2A;
    exp_e = {1'b1, 4'd3, 4'd7, 8'h10, 16'h1234, 10'h2A};
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (out_valid !== 1'b1 || pack_out() !== exp_e || count !== 3'd1) begin
        bad++;
        $display("FAIL single_hold[%0d]: v=%b dat=%h cnt=%0d want 1 %h 1", i, out_valid, pack_out(), count, exp_e);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_fill();
    idle();
    for (int i = 0; i < 4; i++) begin
      drive_req(8'(i));
      tick();
    end
    #1;
    total++;
    if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
      bad++;
      $display("FAIL fill: full=%b rdy=%b cnt=%0d want 1 0 4", full, in_ready, count);
    end
    drive_req(8'd4);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (out_seq_num !== 8'(i)) begin
        bad++;
        $display("FAIL fill_order[%0d]: seq=%0d want %0d", i, out_seq_num, i);
      end
      tick();
    end
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL fill_empty: empty=%b want 1", empty);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 2; i++) begin
      drive_req(8'(i));
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_req(8'(i + 2));
      #1;
      total++;
      if (out_seq_num !== 8'(i)) begin
        bad++;
        $display("FAIL b2b_order[%0d]: seq=%0d want %0d", i, out_seq_num, i);
      end
      tick();
      total++;
      if (count !== 3'd2) begin
        bad++;
        $display("FAIL b2b_count[%0d]: cnt=%0d want 2", i, count);
      end
    end
    drain();
  endtask

  task automatic test_full_pop_push();
    idle();
    for (int i = 0; i < 4; i++) begin
      drive_req(8'(8'h40 + i));
      tick();
    end
    drive_req(8'h99);
    out_ready = 1'b1;
    tick();
    total++;
    if (count !== 3'd3 || full !== 1'b0) begin
      bad++;
      $display("FAIL full_pop_push: cnt=%0d full=%b want 3 0", count, full);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 0; i < 3; i++) begin
      drive_req(8'(8'h30 + i));
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (empty !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid: empty=%b v=%b cnt=%0d want 1 0 0", empty, out_valid, count);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive_req(8'h55);
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_seq_num !== 8'h55) begin
      bad++;
      $display("FAIL reset_mid_head: v=%b seq=%h want 1 55", out_valid, out_seq_num);
    end
    drain();
  endtask

  task automatic test_bypass();
    idle();
    drive_req(8'h22);
    out_ready = 1'b1;
    #1;
    total++;
    if (out_valid !== BYP || (BYP && out_seq_num !== 8'h22)) begin
      bad++;
      $display("FAIL bypass_same_cycle: v=%b seq=%h want v=%b seq=22", out_valid, out_seq_num, BYP);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (count !== (BYP ? 3'd0 : 3'd1)) begin
      bad++;
      $display("FAIL bypass_count: cnt=%0d want %0d", count, BYP ? 0 : 1);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) != 0) drive_req(8'($urandom));
      else in_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_full_pop_push();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sal_bk_req_queue.md
Name: sal_bk_req_queue

Overview:
- Per-bank request queue placed directly downstream of the address decoder, one instance per bank (DRAM_BK_CNT instances).
- Accepts the decoder's bank-selected request (wr, id, len, seq_num, ra, ca) over a valid/ready handshake.
- Buffers the request in a small FIFO and presents it to the bank controller over a second valid/ready handshake.
- Decouples decoder acceptance from bank-controller timing, so AXI address channels stall less often while a bank is busy with ACT/PRE/CAS sequencing.

Parameters:
- DEPTH, 4, number of queued requests; power of two, at least 2.
- ID_W, 4, AXI ID width.
- LEN_W, 4, AXI burst length width.
- SEQ_W, 8, sequence number width.
- RA_W, 16, DRAM row address width.
- CA_W, 10, DRAM column address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid from the decoder.
- in_ready  out  1  queue can accept a request.
- in_wr  in  1  1 = write, 0 = read.
- in_id  in  ID_W  AXI ID.
- in_len  in  LEN_W  AXI length.
- in_seq_num  in  SEQ_W  sequence number.
- in_ra  in  RA_W  row address.
- in_ca  in  CA_W  column address.
- out_valid  out  1  head entry valid to the bank controller.
- out_ready  in  1  bank controller accepts the head entry.
- out_wr, out_id, out_len, out_seq_num, out_ra, out_ca  out  (same widths as the in_* fields)  head entry fields.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - Reset is asynchronous and active-low on rst_n; clock is clk.
  - Reset values: write pointer 0, read pointer 0, count 0.
  - Outputs in reset: empty=1, full=0, out_valid=0, in_ready=1.
  - Storage array is not reset; out_* data fields are don't-care while out_valid=0.
- Reset mid-operation: asserting rst_n low discards all entries immediately (asynchronous). The first push after deassertion lands in entry 0.
- Push: in_valid & in_ready at a clk edge writes all in_* fields into mem[wptr], then wptr increments.
- Pop: out_valid & out_ready at a clk edge increments rptr.
- in_ready = !full. It is combinational from registered state only and never depends on in_valid or out_ready.
- out_valid = !empty. out_* = mem[rptr], driven combinationally from registered storage.
- Latency: a push at edge N shows out_valid=1 after edge N, and the head is visible in cycle N+1 (one-cycle latency).
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- count: +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop or when idle.
- Simultaneous push and pop:
  - Legal when not full and not empty.
  - When full, in_ready=0, so no push occurs even if a pop happens in the same cycle.
  - When empty, out_valid=0, so no pop occurs (without the optional feature).
- Ordering: strict FIFO; entries leave in acceptance order, with seq_num preserved unchanged.
- Protocol assertions:
  - A held entry stays stable while out_valid & !out_ready.
  - Data never changes under an unaccepted head.
  - count never exceeds DEPTH.
  - Flag a push while full or a pop while empty as an error (simulation only).

Optional Feature:
- Macro: SAL_BK_REQ_QUEUE_BYPASS_EN.
- Defined:
  - When empty=1 and in_valid=1, out_valid=1 combinationally and out_* = in_* in the same cycle.
  - If out_ready=1 in that cycle, the request passes through without being written (count stays 0), giving zero-cycle latency.
  - If out_ready=0, the request is written normally and appears from storage in the next cycle.
- Undefined: plain one-cycle-latency FIFO as described above.

Test Plan:
- Reset, then 1 push (wr=1, id=3, len=7, seq=0x10, ra=0x1234, ca=0x2A), out_ready=0 -> cycle after push: out_valid=1, fields match, count=1; out_valid holds with fields stable for 5 cycles.
- Push 4 back-to-back (seq 0,1,2,3) with out_ready=0 -> full=1, in_ready=0, count=4; a 5th in_valid is not accepted; then out_ready=1 for 4 cycles -> pops seq 0,1,2,3 in order, empty=1.
- Fill to 2 entries, then in_valid=1 and out_ready=1 for 10 cycles (seq 2..11) -> count stays 2 throughout; pointers wrap; outputs seq 0..9 in order.
- Full queue (count=4), out_ready=1 and in_valid=1 in the same cycle -> pop occurs, push rejected, count=3 next cycle.
- Fill to 3 entries, assert rst_n=0 between clk edges -> immediately empty=1, out_valid=0, count=0; after release, push seq=0x55 -> appears as head in the next cycle.
- With SAL_BK_REQ_QUEUE_BYPASS_EN, empty queue, in_valid=1, out_ready=1, seq=0x22 -> out_valid=1 and out_seq_num=0x22 in the same cycle, count remains 0.
